// File: rtl/aes_inv_cipher_if.sv
// Start/data/result bundle of the AES-128 inverse cipher; the core takes the slave side.
interface aes_inv_cipher_if;
    logic         AES_en;
    logic [127:0] AES_data_in;
    logic [127:0] AES_key_in;
    logic [127:0] AES_data_out;
    logic         AES_data_out_valid;
    logic         AES_busy;

    modport master (
        output AES_en, AES_data_in, AES_key_in,
        input  AES_data_out, AES_data_out_valid, AES_busy
    );
    modport slave (
        input  AES_en, AES_data_in, AES_key_in,
        output AES_data_out, AES_data_out_valid, AES_busy
    );
endinterface

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 decryption: 10 forward key-expansion cycles, then 10 inverse rounds.
// Optional k10 cache that skips key expansion on a repeated key: define AES_INV_KEY_CACHE_EN.
module aes_inv_cipher (
    input  logic            AES_clk,
    input  logic            AES_rst,
    aes_inv_cipher_if.slave bus
);
    typedef enum logic [1:0] {IDLE, KEYEXP, DEC} state_t;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    // Entry 0 sits in the top byte, so ~x selects the slice directly.
    function automatic logic [7:0] sub_byte(input logic [7:0] x);
        return SBOX[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] inv_sub_byte(input logic [7:0] x);
        return INV_SBOX[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        return {sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0]), sub_byte(w[31:24])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] expand_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h0};
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0]  ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Undo one expansion step: recover w3 first, since SubWord needs the previous w3.
    function automatic logic [127:0] unexpand_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w3 = k[31:0]  ^ k[63:32];
        w2 = k[63:32] ^ k[95:64];
        w1 = k[95:64] ^ k[127:96];
        w0 = k[127:96] ^ sub_rot_word(w3) ^ {rc, 24'h0};
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] a, x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a  = c[31-8*i -: 8];
            x2 = xt(a);
            x4 = xt(x2);
            x8 = xt(x4);
            m9[i] = x8 ^ a;
            mb[i] = x8 ^ x2 ^ a;
            md[i] = x8 ^ x4 ^ a;
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3], m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3], mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    state_t       state_reg, state_next;
    logic [3:0]   cnt_reg, cnt_next;
    logic [127:0] ct_reg, ct_next, key_reg, key_next, st_reg, st_next;
    logic [127:0] data_out_reg, data_out_next;
    logic         valid_reg, valid_next;
    logic [127:0] key_exp, k_cnt, isb, ark, imc, cached_k10;
    logic         cache_hit;

    assign key_exp = expand_key(key_reg, rcon(cnt_reg));
    assign k_cnt   = unexpand_key(key_reg, rcon(cnt_reg + 4'd1));

    // InvShiftRows folded into the S-box inputs: row r takes its byte from column c-r.
    for (genvar gi = 0; gi < 16; gi++) begin : g_inv_sub
        localparam int SRC = (gi % 4) + 4 * (((gi / 4) + 4 - (gi % 4)) % 4);
        assign isb[127-8*gi -: 8] = inv_sub_byte(st_reg[127-8*SRC -: 8]);
    end
    assign ark = isb ^ k_cnt;
    for (genvar gi = 0; gi < 4; gi++) begin : g_inv_mix
        assign imc[127-32*gi -: 32] = inv_mix_col(ark[127-32*gi -: 32]);
    end

`ifdef AES_INV_KEY_CACHE_EN
    logic         cache_valid_reg;
    logic [127:0] cache_key_reg, cache_k10_reg;

    assign cache_hit  = cache_valid_reg && (bus.AES_key_in == cache_key_reg);
    assign cached_k10 = cache_k10_reg;

    // The key is latched at accept; the entry only becomes valid once k10 is known.
    always_ff @(posedge AES_clk or posedge AES_rst) begin
        if (AES_rst) begin
            cache_valid_reg <= 1'b0;
            cache_key_reg   <= '0;
            cache_k10_reg   <= '0;
        end else if (state_reg == IDLE && bus.AES_en && !cache_hit) begin
            cache_valid_reg <= 1'b0;
            cache_key_reg   <= bus.AES_key_in;
        end else if (state_reg == KEYEXP && cnt_reg == 4'd10) begin
            cache_valid_reg <= 1'b1;
            cache_k10_reg   <= key_exp;
        end
    end
`else
    assign cache_hit  = 1'b0;
    assign cached_k10 = '0;
`endif

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        ct_next       = ct_reg;
        key_next      = key_reg;
        st_next       = st_reg;
        data_out_next = data_out_reg;
        valid_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.AES_en && cache_hit) begin
                    st_next    = bus.AES_data_in ^ cached_k10;
                    key_next   = cached_k10;
                    cnt_next   = 4'd9;
                    state_next = DEC;
                end else if (bus.AES_en) begin
                    ct_next    = bus.AES_data_in;
                    key_next   = bus.AES_key_in;
                    cnt_next   = 4'd1;
                    state_next = KEYEXP;
                end
            end
            KEYEXP: begin
                key_next = key_exp;
                if (cnt_reg == 4'd10) begin
                    st_next    = ct_reg ^ key_exp;
                    cnt_next   = 4'd9;
                    state_next = DEC;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            DEC: begin
                key_next = k_cnt;
                if (cnt_reg == 4'd0) begin
                    st_next       = ark;
                    data_out_next = ark;
                    valid_next    = 1'b1;
                    state_next    = IDLE;
                end else begin
                    st_next  = imc;
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge AES_clk or posedge AES_rst) begin
        if (AES_rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= 4'd0;
            ct_reg       <= '0;
            key_reg      <= '0;
            st_reg       <= '0;
            data_out_reg <= '0;
            valid_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            ct_reg       <= ct_next;
            key_reg      <= key_next;
            st_reg       <= st_next;
            data_out_reg <= data_out_next;
            valid_reg    <= valid_next;
        end
    end

    assign bus.AES_data_out       = data_out_reg;
    assign bus.AES_data_out_valid = valid_reg;
    assign bus.AES_busy           = (state_reg != IDLE);
endmodule

// File: tb/tb_aes_inv_cipher.sv
// Bench for aes_inv_cipher: FIPS-197 vectors plus round trips through a forward-cipher model.
module tb_aes_inv_cipher;
    logic AES_clk = 1'b0;
    logic AES_rst = 1'b1;

    aes_inv_cipher_if bus ();
    aes_inv_cipher dut (.AES_clk(AES_clk), .AES_rst(AES_rst), .bus(bus));

    always #5 AES_clk = ~AES_clk;

`ifdef AES_INV_KEY_CACHE_EN
    localparam int HIT_LAT = 10;
    localparam int B2B_GAP = 11;
`else
    localparam int HIT_LAT = 20;
    localparam int B2B_GAP = 21;
`endif
    localparam int MISS_LAT = 20;

    int           n_cmp = 0;
    int           n_mis = 0;
    logic [127:0] exp_q [$];
    logic [7:0]   sb [256];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box from the GF(2^8) inverse and the affine map, independent of any lookup table.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int v = 0; v < 256; v++) begin
            inv = 8'h00;
            if (v != 0) begin
                inv = 8'h01;
                for (int e = 0; e < 254; e++) inv = gf_mul(inv, 8'(v));
            end
            sb[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                  ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] rk, res;
        logic [31:0]  tw;
        logic [7:0]   rc, a0, a1, a2, a3;
        rk = key;
        rc = 8'h01;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ key[127-8*i -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)]];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    t[4*c]   = gf_mul(a0, 8'h02) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3;
                    t[4*c+1] = a0 ^ gf_mul(a1, 8'h02) ^ gf_mul(a2, 8'h03) ^ a3;
                    t[4*c+2] = a0 ^ a1 ^ gf_mul(a2, 8'h02) ^ gf_mul(a3, 8'h03);
                    t[4*c+3] = gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ gf_mul(a3, 8'h02);
                end
            end
            tw = {sb[rk[23:16]], sb[rk[15:8]], sb[rk[7:0]], sb[rk[31:24]]} ^ {rc, 24'h0};
            rk[127:96] = rk[127:96] ^ tw;
            rk[95:64]  = rk[95:64] ^ rk[127:96];
            rk[63:32]  = rk[63:32] ^ rk[95:64];
            rk[31:0]   = rk[31:0] ^ rk[63:32];
            rc = gf_mul(rc, 8'h02);
            for (int i = 0; i < 16; i++) s[i] = t[i] ^ rk[127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    task automatic tick();
        @(posedge AES_clk);
        #1;
    endtask

    task automatic start(input logic [127:0] key, input logic [127:0] ct,
                         input logic [127:0] pt, input bit track);
        bus.AES_en      = 1'b1;
        bus.AES_key_in  = key;
        bus.AES_data_in = ct;
        if (track) exp_q.push_back(pt);
        tick();
        bus.AES_en = 1'b0;
    endtask

    // Waits for the next valid pulse, k0 cycles already elapsed since the reference edge.
    task automatic wait_valid(input int exp_lat, input int k0, input string tag);
        int           k;
        logic         busy_ok;
        logic [127:0] pt;
        k = k0;
        busy_ok = 1'b1;
        while (k < 60) begin
            tick();
            k++;
            if (bus.AES_data_out_valid) break;
            if (!bus.AES_busy) busy_ok = 1'b0;
        end
        check({tag, " latency"}, 128'(k), 128'(exp_lat));
        check({tag, " busy while running"}, 128'(busy_ok), 128'd1);
        check({tag, " busy in valid cycle"}, 128'(bus.AES_busy), 128'd0);
        check({tag, " result expected"}, 128'(exp_q.size() > 0), 128'd1);
        if (exp_q.size() > 0) begin
            pt = exp_q.pop_front();
            check({tag, " plaintext"}, bus.AES_data_out, pt);
        end
        $display("[%0t] %s: pt=%h latency=%0d", $time, tag, bus.AES_data_out, k);
    endtask

    task automatic expect_quiet(input int cycles, input string tag);
        int pulses;
        pulses = 0;
        repeat (cycles) begin
            tick();
            if (bus.AES_data_out_valid) pulses++;
        end
        check({tag, " no stray valid"}, 128'(pulses), 128'd0);
        check({tag, " idle afterwards"}, 128'(bus.AES_busy), 128'd0);
    endtask

    initial begin
        logic [127:0] k_rt, pt_rt, k_bb, pt_a, pt_b, pt_c, k_r, p_r;
        bus.AES_en      = 1'b0;
        bus.AES_data_in = '0;
        bus.AES_key_in  = '0;
        build_sbox();
        repeat (3) @(posedge AES_clk);
        #1;
        check("reset data_out", bus.AES_data_out, 128'h0);
        check("reset valid", 128'(bus.AES_data_out_valid), 128'h0);
        check("reset busy", 128'(bus.AES_busy), 128'h0);
        AES_rst = 1'b0;
        tick();

        start(128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
              128'h00112233445566778899aabbccddeeff, 1'b1);
        wait_valid(MISS_LAT, 0, "fips C.1");
        tick();
        check("C.1 valid single cycle", 128'(bus.AES_data_out_valid), 128'd0);
        tick();
        tick();
        check("C.1 data_out held", bus.AES_data_out, 128'h00112233445566778899aabbccddeeff);

        start(128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32,
              128'h3243f6a8885a308d313198a2e0370734, 1'b1);
        wait_valid(MISS_LAT, 0, "fips B");

        // Inputs scrambled and an extra start pulse while busy must not disturb the result.
        k_rt  = 128'haa2bdb40bff6a5e8caa9ba3ebc1e2acc;
        pt_rt = 128'h000000b7000000000000000000000000;
        start(k_rt, aes_enc(pt_rt, k_rt), pt_rt, 1'b1);
        tick();
        tick();
        bus.AES_data_in = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.AES_key_in  = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.AES_en = 1'b1;
        tick();
        bus.AES_en = 1'b0;
        wait_valid(MISS_LAT, 3, "round trip");
        expect_quiet(25, "round trip");

        // Level-held enable across two operations under one fresh key.
        k_bb = {$urandom(), $urandom(), $urandom(), $urandom()};
        pt_a = {$urandom(), $urandom(), $urandom(), $urandom()};
        pt_b = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.AES_en      = 1'b1;
        bus.AES_key_in  = k_bb;
        bus.AES_data_in = aes_enc(pt_a, k_bb);
        exp_q.push_back(pt_a);
        exp_q.push_back(pt_b);
        tick();
        bus.AES_data_in = aes_enc(pt_b, k_bb);
        wait_valid(MISS_LAT, 0, "b2b first");
        wait_valid(B2B_GAP, 0, "b2b second");
        bus.AES_en = 1'b0;

        pt_c = {$urandom(), $urandom(), $urandom(), $urandom()};
        start(k_bb, aes_enc(pt_c, k_bb), pt_c, 1'b1);
        wait_valid(HIT_LAT, 0, "same key again");

        k_r = {$urandom(), $urandom(), $urandom(), $urandom()};
        p_r = {$urandom(), $urandom(), $urandom(), $urandom()};
        start(k_r, aes_enc(p_r, k_r), p_r, 1'b1);
        wait_valid(MISS_LAT, 0, "new key");

        // Abort an operation mid-flight; the retry under the same key must pay full latency.
        start(k_r, aes_enc(~p_r, k_r), ~p_r, 1'b0);
        repeat (6) tick();
        AES_rst = 1'b1;
        #1;
        check("abort data_out", bus.AES_data_out, 128'h0);
        check("abort valid", 128'(bus.AES_data_out_valid), 128'h0);
        check("abort busy", 128'(bus.AES_busy), 128'h0);
        tick();
        AES_rst = 1'b0;
        expect_quiet(25, "after abort");
        start(k_r, aes_enc(~p_r, k_r), ~p_r, 1'b1);
        wait_valid(MISS_LAT, 0, "after abort");

        for (int n = 0; n < 3; n++) begin
            k_r = {$urandom(), $urandom(), $urandom(), $urandom()};
            p_r = {$urandom(), $urandom(), $urandom(), $urandom()};
            start(k_r, aes_enc(p_r, k_r), p_r, 1'b1);
            wait_valid(MISS_LAT, 0, "random");
        end

        check("scoreboard drained", 128'(exp_q.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/aes_inv_cipher.md
# aes_inv_cipher

Iterative AES-128 decryption core: the inverse-cipher counterpart of `AES_top`, which encrypts. It accepts a 128-bit ciphertext and the original 128-bit cipher key, derives the round-10 key on chip, then runs the inverse rounds back to the plaintext, one round per clock. It sits beside `AES_top` in the same clock domain and reuses its port naming and its enable/valid handshake, so plaintext → `AES_top` → this block must round-trip exactly.

## Interface
Parameters:
- none (AES-128 only; 10 rounds fixed)

Ports:
- `AES_clk`  in  1  sole clock; all state updates on the rising edge
- `AES_rst`  in  1  reset; asynchronous, active-high
- `AES_en`  in  1  start request; sampled only in IDLE
- `AES_data_in`  in  128  ciphertext; byte 0 = bits [127:120], FIPS-197 column-major order
- `AES_key_in`  in  128  cipher key, the same key given to `AES_top`
- `AES_data_out`  out  128  recovered plaintext; holds its value until the next result
- `AES_data_out_valid`  out  1  one-cycle pulse when `AES_data_out` is updated
- `AES_busy`  out  1  high while an operation is in flight

## Operation
- **State machine:** IDLE → KEYEXP → DEC → IDLE.
- **IDLE:**
  - When `AES_en`=1, capture the ciphertext into `ct_r` and the key into `key_r`.
  - Set round counter `cnt`=1 and go to KEYEXP.
  - When `AES_en`=0, stay in IDLE.
- **KEYEXP (10 cycles, `cnt` = 1..10):**
  - Each cycle, `key_r` ← forward key expansion of `key_r` using Rcon[`cnt`] (Rcon = 01,02,04,08,10,20,40,80,1b,36).
  - On `cnt`=10, also load `st_r` ← `ct_r` XOR (expanded key, i.e. k10).
  - Then set `cnt`=9 and go to DEC.
- **DEC (10 cycles, `cnt` = 9 down to 0):**
  - Derive `k_cnt` combinationally by inverse key expansion of `key_r` with Rcon[`cnt`+1]:
    - w3' = w3^w2, w2' = w2^w1, w1' = w1^w0
    - w0' = w0 ^ SubWord(RotWord(w3')) ^ Rcon
  - `key_r` ← `k_cnt`.
  - `st_r` ← InvMixColumns(InvSubBytes(InvShiftRows(`st_r`)) XOR `k_cnt`).
  - On `cnt`=0, omit InvMixColumns. Then load `AES_data_out`, pulse valid, and return to IDLE.
- `AES_en` is ignored outside IDLE. `AES_data_in` and `AES_key_in` may change freely after the capture edge.
- **Arithmetic:** GF(2^8) with polynomial 0x11b. InvMixColumns coefficients are 0e,0b,0d,09. Inverse S-box is a 256-entry combinational table.

## Timing
- Reset values: `AES_data_out`=0, `AES_data_out_valid`=0, `AES_busy`=0, state=IDLE, `cnt`=0, key cache invalid.
- **Latency:** with `AES_en` sampled at edge E0, `AES_data_out_valid` is high for the cycle following edge E20. With a cache hit (see Configuration), the pulse follows edge E10.
- **`AES_busy`:**
  - High from the cycle after E0 through the cycle after E19.
  - Low in the valid cycle, because the FSM is already back in IDLE.
- **Back-to-back:** `AES_en` held high during the valid cycle starts the next operation at that edge. Level-held `AES_en` therefore produces one result every 21 cycles (every 11 on a cache hit).
- **Reset mid-operation:** the operation aborts immediately. No valid pulse is produced and `AES_data_out` returns to 0.
- There is no backpressure. Downstream logic must accept `AES_data_out` on the valid pulse, or read it before the next valid pulse.

## Configuration
- Macro: `AES_INV_KEY_CACHE_EN`.
- **Defined:**
  - At the end of each KEYEXP, store k10 and the originating cipher key in cache registers and mark the cache valid.
  - In IDLE, if `AES_en`=1 and `AES_key_in` equals the cached key while the cache is valid, skip KEYEXP:
    - load `st_r` ← `AES_data_in` XOR cached k10;
    - load `key_r` ← cached k10;
    - set `cnt`=9 and enter DEC directly.
  - Reset invalidates the cache.
- **Undefined:** no cache registers exist, and every operation runs KEYEXP (fixed 20-cycle latency).

## Test plan
- **FIPS-197 C.1:** key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a → pt 00112233445566778899aabbccddeeff; valid pulses exactly 20 cycles after the accept edge.
- **FIPS-197 B:** key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 → pt 3243f6a8885a308d313198a2e0370734.
- **Round-trip:** key aa2bdb40bff6a5e8caa9ba3ebc1e2acc, pt 000000b7000000000000000000000000 encrypted by `AES_top` and fed to this block → identical pt. Changing `AES_data_in` while busy → result unaffected; extra `AES_en` pulses while busy are ignored.
- **Back-to-back:** `AES_en` held high for two ciphertexts under the same key → two valid pulses 21 cycles apart. With `AES_INV_KEY_CACHE_EN` defined, the second pulse comes 11 cycles after the first and the result is still correct; a different key afterwards → 20-cycle latency again.
- **Reset abort:** assert `AES_rst` at cycle 7 of an operation → `AES_data_out`=0, valid and busy low, no pulse produced. A new `AES_en` after reset release → correct result with full latency (cache invalidated).
